alu_issue_scheduler: RTL and testbench
======================================

Name: alu_issue_scheduler

Overview:
Reservation-station scheduler in front of the ALU. Holds up to ENTRIES dispatched ALU/branch/jump micro-ops and snoops two result broadcast buses to capture pending operands. Each cycle it issues one ready entry to the ALU through registered outputs, and drives NOP when no entry is ready. Sits between the dispatch/decode stage and the ALU; the ROB flush clears it.

Parameters:
ENTRIES, 8, number of station slots (power of two, ≥2)
IDWidth, 32, data/immediate width
ROBWidth, 4, ROB tag width; tag 0 = "no dependency / no broadcast"
AddressWidth, 32, PC width
InstTypeWidth, 6, opcode width
NOP_OP, 0, opcode value meaning "no operation"

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global enable; low = hold all state
disp_valid_in  input  1  dispatch request this cycle
disp_opcode_in  input  InstTypeWidth  micro-op type
disp_a_in  input  IDWidth  immediate
disp_vj_in / disp_vk_in  input  IDWidth  operand values, meaningful when the matching tag is 0
disp_qj_in / disp_qk_in  input  ROBWidth  producer tags (0 = value valid)
disp_dest_in  input  ROBWidth  destination ROB tag
disp_pc_in  input  AddressWidth  instruction PC
disp_full_out  output  1  no free slot (combinational from registered state)
cdb0_tag_in / cdb1_tag_in  input  ROBWidth  broadcast tags (0 = idle)
cdb0_val_in / cdb1_val_in  input  IDWidth  broadcast values
rob_flush_in  input  1  misprediction flush
sched_alu_opcode_out  output  InstTypeWidth  issued opcode (registered)
sched_alu_a_out / sched_alu_vj_out / sched_alu_vk_out  output  IDWidth  issued operands
sched_alu_dest_out  output  ROBWidth  issued destination tag
sched_alu_pc_out  output  AddressWidth  issued PC
count_out  output  $clog2(ENTRIES)+1  occupied-slot count

Behaviour:
- Reset (rst_in=0, async): all busy bits clear; count_out=0; opcode_out=NOP_OP; all other outputs 0. Reset mid-operation discards all entries immediately.
- rdy_in=0: no state change, outputs held, dispatch ignored, broadcasts missed (producers re-broadcast is not assumed; upstream must also stall).
- Per entry: busy, opcode, a, vj, qj, vk, qk, dest, pc.
- Dispatch: if disp_valid_in & !disp_full_out & !rob_flush_in, write into lowest-index non-busy slot at the edge. Same-cycle capture: if disp_qj_in≠0 and equals a nonzero cdbN_tag_in, store that value and qj=0 (cdb0 wins if both match); same for k.
- Snoop: for each busy entry with qj≠0 matching a nonzero broadcast tag, latch the value and clear qj; same for k. Both operands may resolve in one cycle.
- Ready = busy & qj==0 & qk==0, evaluated on registered state. An operand captured at edge t makes the entry issuable at edge t+1; there is no same-cycle bypass.
- Issue: select the lowest-index ready entry. At the edge, load its fields into the output registers and clear its busy bit. With no ready entry, opcode_out=NOP_OP and other outputs hold. Issue-to-ALU latency is 1 cycle from readiness.
- Simultaneous issue and dispatch: allowed. The slot freed by an issue is not reusable in the same cycle, because free/full is computed from pre-edge state.
- count_out next = count + accepted dispatch − issue; it never wraps and is always ≤ ENTRIES.
- disp_full_out = (count_out == ENTRIES). A dispatch while full is dropped silently; upstream must stall.
- Flush: at the edge, clear all busy bits, count_out=0, opcode_out=NOP_OP. Same-cycle dispatch and issue are suppressed. Flush has priority over everything except reset.

Test Plan:
- Reset then idle: rst_in low→high; no dispatch → opcode_out=NOP_OP, count_out=0, disp_full_out=0 for 10 cycles.
- Ready dispatch: ADD, qj=qk=0, vj=5, vk=7, dest=3 at edge t → count=1 after t. At edge t+1, opcode=ADD, vj=5, vk=7, dest=3, count=0.
- Operand wakeup: dispatch qj=6, vk=2. Cycle later cdb1_tag=6, val=0x10 → issue one edge after capture with vj=0x10. cdb0/cdb1 both tag 6 with different values → cdb0 value issued.
- Same-cycle capture: dispatch qk=9 while cdb0_tag=9, val=0xFF → entry stored ready and issues the next edge with vk=0xFF.
- Fill/full: 8 dependent dispatches (qj=5) → disp_full_out=1, count=8; a 9th dispatch is dropped. Broadcast tag 5 → entries issue from slot 0 upward, one per cycle, count reaching 0 after 8 issues.
- Flush: 4 entries busy plus a dispatch in the flush cycle → next cycle count=0, opcode=NOP_OP, and a later broadcast causes no issue.

Source files
------------

// File: rtl/alu_issue_scheduler.sv
// ALU reservation station: holds dispatched micro-ops, snoops two result
// buses for pending operands and issues the lowest ready slot each cycle.
module alu_issue_scheduler #(
   parameter int ENTRIES       = 8,
   parameter int IDWidth       = 32,
   parameter int ROBWidth      = 4,
   parameter int AddressWidth  = 32,
   parameter int InstTypeWidth = 6,
   parameter logic [InstTypeWidth-1:0] NOP_OP = '0
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        rdy_in,
   input  logic                        disp_valid_in,
   input  logic [InstTypeWidth-1:0]    disp_opcode_in,
   input  logic [IDWidth-1:0]          disp_a_in,
   input  logic [IDWidth-1:0]          disp_vj_in,
   input  logic [IDWidth-1:0]          disp_vk_in,
   input  logic [ROBWidth-1:0]         disp_qj_in,
   input  logic [ROBWidth-1:0]         disp_qk_in,
   input  logic [ROBWidth-1:0]         disp_dest_in,
   input  logic [AddressWidth-1:0]     disp_pc_in,
   output logic                        disp_full_out,
   input  logic [ROBWidth-1:0]         cdb0_tag_in,
   input  logic [IDWidth-1:0]          cdb0_val_in,
   input  logic [ROBWidth-1:0]         cdb1_tag_in,
   input  logic [IDWidth-1:0]          cdb1_val_in,
   input  logic                        rob_flush_in,
   output logic [InstTypeWidth-1:0]    sched_alu_opcode_out,
   output logic [IDWidth-1:0]          sched_alu_a_out,
   output logic [IDWidth-1:0]          sched_alu_vj_out,
   output logic [IDWidth-1:0]          sched_alu_vk_out,
   output logic [ROBWidth-1:0]         sched_alu_dest_out,
   output logic [AddressWidth-1:0]     sched_alu_pc_out,
   output logic [$clog2(ENTRIES):0]    count_out
);

   localparam int IW = $clog2(ENTRIES);
   localparam int CW = IW + 1;

   logic [ENTRIES-1:0]                     busy_q, busy_d;
   logic [ENTRIES-1:0][InstTypeWidth-1:0]  op_q, op_d;
   logic [ENTRIES-1:0][IDWidth-1:0]        a_q, a_d;
   logic [ENTRIES-1:0][IDWidth-1:0]        vj_q, vj_d;
   logic [ENTRIES-1:0][IDWidth-1:0]        vk_q, vk_d;
   logic [ENTRIES-1:0][ROBWidth-1:0]       qj_q, qj_d;
   logic [ENTRIES-1:0][ROBWidth-1:0]       qk_q, qk_d;
   logic [ENTRIES-1:0][ROBWidth-1:0]       dest_q, dest_d;
   logic [ENTRIES-1:0][AddressWidth-1:0]   pc_q, pc_d;
   logic [CW-1:0]                          count_q, count_d;

   logic [InstTypeWidth-1:0] o_op_q, o_op_d;
   logic [IDWidth-1:0]       o_a_q, o_a_d;
   logic [IDWidth-1:0]       o_vj_q, o_vj_d;
   logic [IDWidth-1:0]       o_vk_q, o_vk_d;
   logic [ROBWidth-1:0]      o_dest_q, o_dest_d;
   logic [AddressWidth-1:0]  o_pc_q, o_pc_d;

   logic          free_found, rdy_found, full, disp_acc, iss;
   logic [IW-1:0] free_idx, rdy_idx;

   always_comb begin
      busy_d   = busy_q;
      op_d     = op_q;
      a_d      = a_q;
      vj_d     = vj_q;
      vk_d     = vk_q;
      qj_d     = qj_q;
      qk_d     = qk_q;
      dest_d   = dest_q;
      pc_d     = pc_q;
      count_d  = count_q;
      o_op_d   = o_op_q;
      o_a_d    = o_a_q;
      o_vj_d   = o_vj_q;
      o_vk_d   = o_vk_q;
      o_dest_d = o_dest_q;
      o_pc_d   = o_pc_q;
      free_found = 1'b0;
      free_idx   = '0;
      rdy_found  = 1'b0;
      rdy_idx    = '0;

      // Both pickers look only at pre-edge state: no same-cycle reuse or bypass.
      for (int i = 0; i < ENTRIES; i++) begin
         if (!busy_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
         if (busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0 && !rdy_found) begin
            rdy_found = 1'b1;
            rdy_idx   = IW'(i);
         end
      end

      full     = (count_q == CW'(ENTRIES));
      disp_acc = disp_valid_in && !full && !rob_flush_in;
      iss      = rdy_found && !rob_flush_in;

      for (int i = 0; i < ENTRIES; i++) begin
         if (busy_q[i] && qj_q[i] != '0) begin
            if (qj_q[i] == cdb0_tag_in) begin
               vj_d[i] = cdb0_val_in;
               qj_d[i] = '0;
            end else if (qj_q[i] == cdb1_tag_in) begin
               vj_d[i] = cdb1_val_in;
               qj_d[i] = '0;
            end
         end
         if (busy_q[i] && qk_q[i] != '0) begin
            if (qk_q[i] == cdb0_tag_in) begin
               vk_d[i] = cdb0_val_in;
               qk_d[i] = '0;
            end else if (qk_q[i] == cdb1_tag_in) begin
               vk_d[i] = cdb1_val_in;
               qk_d[i] = '0;
            end
         end
      end

      if (iss) begin
         busy_d[rdy_idx] = 1'b0;
         o_op_d   = op_q[rdy_idx];
         o_a_d    = a_q[rdy_idx];
         o_vj_d   = vj_q[rdy_idx];
         o_vk_d   = vk_q[rdy_idx];
         o_dest_d = dest_q[rdy_idx];
         o_pc_d   = pc_q[rdy_idx];
      end else begin
         o_op_d = NOP_OP;
      end

      if (disp_acc) begin
         busy_d[free_idx] = 1'b1;
         op_d[free_idx]   = disp_opcode_in;
         a_d[free_idx]    = disp_a_in;
         dest_d[free_idx] = disp_dest_in;
         pc_d[free_idx]   = disp_pc_in;
         vj_d[free_idx]   = disp_vj_in;
         qj_d[free_idx]   = disp_qj_in;
         vk_d[free_idx]   = disp_vk_in;
         qk_d[free_idx]   = disp_qk_in;
         if (disp_qj_in != '0) begin
            if (disp_qj_in == cdb0_tag_in) begin
               vj_d[free_idx] = cdb0_val_in;
               qj_d[free_idx] = '0;
            end else if (disp_qj_in == cdb1_tag_in) begin
               vj_d[free_idx] = cdb1_val_in;
               qj_d[free_idx] = '0;
            end
         end
         if (disp_qk_in != '0) begin
            if (disp_qk_in == cdb0_tag_in) begin
               vk_d[free_idx] = cdb0_val_in;
               qk_d[free_idx] = '0;
            end else if (disp_qk_in == cdb1_tag_in) begin
               vk_d[free_idx] = cdb1_val_in;
               qk_d[free_idx] = '0;
            end
         end
      end

      count_d = count_q + CW'(disp_acc) - CW'(iss);

      if (rob_flush_in) begin
         busy_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_q   <= '0;
         op_q     <= '0;
         a_q      <= '0;
         vj_q     <= '0;
         vk_q     <= '0;
         qj_q     <= '0;
         qk_q     <= '0;
         dest_q   <= '0;
         pc_q     <= '0;
         count_q  <= '0;
         o_op_q   <= NOP_OP;
         o_a_q    <= '0;
         o_vj_q   <= '0;
         o_vk_q   <= '0;
         o_dest_q <= '0;
         o_pc_q   <= '0;
      end else if (rdy_in) begin
         busy_q   <= busy_d;
         op_q     <= op_d;
         a_q      <= a_d;
         vj_q     <= vj_d;
         vk_q     <= vk_d;
         qj_q     <= qj_d;
         qk_q     <= qk_d;
         dest_q   <= dest_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         o_op_q   <= o_op_d;
         o_a_q    <= o_a_d;
         o_vj_q   <= o_vj_d;
         o_vk_q   <= o_vk_d;
         o_dest_q <= o_dest_d;
         o_pc_q   <= o_pc_d;
      end
   end

   assign disp_full_out        = full;
   assign count_out            = count_q;
   assign sched_alu_opcode_out = o_op_q;
   assign sched_alu_a_out      = o_a_q;
   assign sched_alu_vj_out     = o_vj_q;
   assign sched_alu_vk_out     = o_vk_q;
   assign sched_alu_dest_out   = o_dest_q;
   assign sched_alu_pc_out     = o_pc_q;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: vector table plus issue scoreboard
// and directed sequences for wakeup, fill, flush, stall and reset.
module tb_alu_issue_scheduler;

   localparam logic [5:0] NOP = 6'd0;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] vj;
      logic [31:0] vk;
      logic [3:0]  dest;
      logic [31:0] pc;
   } iss_t;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] vj;
      logic [31:0] vk;
      logic [3:0]  dest;
      logic [31:0] pc;
      logic [3:0]  exp_count;
   } vec_t;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        disp_valid_in;
   logic [5:0]  disp_opcode_in;
   logic [31:0] disp_a_in, disp_vj_in, disp_vk_in;
   logic [3:0]  disp_qj_in, disp_qk_in, disp_dest_in;
   logic [31:0] disp_pc_in;
   logic        disp_full_out;
   logic [3:0]  cdb0_tag_in, cdb1_tag_in;
   logic [31:0] cdb0_val_in, cdb1_val_in;
   logic        rob_flush_in;
   logic [5:0]  sched_alu_opcode_out;
   logic [31:0] sched_alu_a_out, sched_alu_vj_out, sched_alu_vk_out;
   logic [3:0]  sched_alu_dest_out;
   logic [31:0] sched_alu_pc_out;
   logic [3:0]  count_out;

   int   checks = 0;
   int   failures = 0;
   iss_t sb[$];

   alu_issue_scheduler dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .disp_valid_in(disp_valid_in), .disp_opcode_in(disp_opcode_in),
      .disp_a_in(disp_a_in), .disp_vj_in(disp_vj_in),
      .disp_vk_in(disp_vk_in), .disp_qj_in(disp_qj_in),
      .disp_qk_in(disp_qk_in), .disp_dest_in(disp_dest_in),
      .disp_pc_in(disp_pc_in), .disp_full_out(disp_full_out),
      .cdb0_tag_in(cdb0_tag_in), .cdb0_val_in(cdb0_val_in),
      .cdb1_tag_in(cdb1_tag_in), .cdb1_val_in(cdb1_val_in),
      .rob_flush_in(rob_flush_in),
      .sched_alu_opcode_out(sched_alu_opcode_out),
      .sched_alu_a_out(sched_alu_a_out),
      .sched_alu_vj_out(sched_alu_vj_out),
      .sched_alu_vk_out(sched_alu_vk_out),
      .sched_alu_dest_out(sched_alu_dest_out),
      .sched_alu_pc_out(sched_alu_pc_out),
      .count_out(count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Every issued op must match the oldest expected entry.
   task automatic check_issue(input string name);
      iss_t act, exp;
      if (sched_alu_opcode_out !== NOP) begin
         act = {sched_alu_opcode_out, sched_alu_a_out, sched_alu_vj_out,
                sched_alu_vk_out, sched_alu_dest_out, sched_alu_pc_out};
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected_issue actual=%h expected=none",
                     name, act);
         end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
               failures++;
               $display("FAIL %s issue actual=%h expected=%h",
                        name, act, exp);
            end
         end
      end
   endtask

   task automatic idle();
      disp_valid_in  = 1'b0;
      disp_opcode_in = '0;
      disp_a_in      = '0;
      disp_vj_in     = '0;
      disp_vk_in     = '0;
      disp_qj_in     = '0;
      disp_qk_in     = '0;
      disp_dest_in   = '0;
      disp_pc_in     = '0;
      cdb0_tag_in    = '0;
      cdb0_val_in    = '0;
      cdb1_tag_in    = '0;
      cdb1_val_in    = '0;
      rob_flush_in   = 1'b0;
   endtask

   task automatic disp(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] vj, input logic [3:0] qj,
                       input logic [31:0] vk, input logic [3:0] qk,
                       input logic [3:0] dest, input logic [31:0] pc);
      disp_valid_in  = 1'b1;
      disp_opcode_in = op;
      disp_a_in      = a;
      disp_vj_in     = vj;
      disp_qj_in     = qj;
      disp_vk_in     = vk;
      disp_qk_in     = qk;
      disp_dest_in   = dest;
      disp_pc_in     = pc;
   endtask

   task automatic drain(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check_issue(name);
      end
      chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{6'd1, 32'h0, 32'd5, 32'd7, 4'd3, 32'h1000, 4'd1};
      vecs[1] = '{6'd2, 32'h11, 32'hFFFF_FFFF, 32'h1, 4'd15, 32'h1004, 4'd1};
      vecs[2] = '{6'd63, 32'hDEAD_BEEF, 32'h0, 32'h8000_0000, 4'd1,
                  32'hFFFF_FFFC, 4'd1};
      vecs[3] = '{6'd9, 32'h1234, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'd8,
                  32'h2000, 4'd1};

      idle();
      rdy_in = 1'b1;
      rst_in = 1'b0;
      #12;
      chk("reset_count", 64'(count_out), 64'd0);
      chk("reset_opcode", 64'(sched_alu_opcode_out), 64'(NOP));
      chk("reset_dest", 64'(sched_alu_dest_out), 64'd0);
      chk("reset_pc", 64'(sched_alu_pc_out), 64'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_opcode", 64'(sched_alu_opcode_out), 64'(NOP));
         chk("idle_count", 64'(count_out), 64'd0);
         chk("idle_full", 64'(disp_full_out), 64'd0);
      end

      // Ready ops back to back: one enters as one leaves.
      for (int i = 0; i < 4; i++) begin
         disp(vecs[i].op, vecs[i].a, vecs[i].vj, 4'd0, vecs[i].vk, 4'd0,
              vecs[i].dest, vecs[i].pc);
         sb.push_back({vecs[i].op, vecs[i].a, vecs[i].vj, vecs[i].vk,
                       vecs[i].dest, vecs[i].pc});
         tick();
         check_issue("vec");
         chk("vec_count", 64'(count_out), 64'(vecs[i].exp_count));
      end
      idle();
      drain("vec_drain", 3);
      chk("vec_count_end", 64'(count_out), 64'd0);

      // Wakeup through cdb1.
      disp(6'd1, 32'h0, 32'hBAD, 4'd6, 32'd2, 4'd0, 4'd4, 32'h3000);
      tick();
      check_issue("wake1");
      idle();
      cdb1_tag_in = 4'd6;
      cdb1_val_in = 32'h10;
      sb.push_back({6'd1, 32'h0, 32'h10, 32'd2, 4'd4, 32'h3000});
      tick();
      chk("wake1_no_early", 64'(sched_alu_opcode_out), 64'(NOP));
      idle();
      tick();
      check_issue("wake1");
      chk("wake1_sb", 64'(sb.size()), 64'd0);
      chk("wake1_count", 64'(count_out), 64'd0);

      // Both buses broadcast the tag: cdb0 wins.
      disp(6'd3, 32'h7, 32'hBAD, 4'd6, 32'd2, 4'd0, 4'd5, 32'h3004);
      tick();
      idle();
      cdb0_tag_in = 4'd6;
      cdb0_val_in = 32'hAA;
      cdb1_tag_in = 4'd6;
      cdb1_val_in = 32'hBB;
      sb.push_back({6'd3, 32'h7, 32'hAA, 32'd2, 4'd5, 32'h3004});
      tick();
      check_issue("wake2");
      idle();
      tick();
      check_issue("wake2");
      chk("wake2_sb", 64'(sb.size()), 64'd0);

      // Capture at dispatch.
      disp(6'd4, 32'h0, 32'd1, 4'd0, 32'hBAD, 4'd9, 4'd6, 32'h4000);
      cdb0_tag_in = 4'd9;
      cdb0_val_in = 32'hFF;
      sb.push_back({6'd4, 32'h0, 32'd1, 32'hFF, 4'd6, 32'h4000});
      tick();
      chk("same_no_early", 64'(sched_alu_opcode_out), 64'(NOP));
      idle();
      tick();
      check_issue("same");
      chk("same_sb", 64'(sb.size()), 64'd0);

      // Fill to full, drop the 9th, then release all.
      for (int i = 0; i < 8; i++) begin
         disp(6'd5, 32'(i), 32'd0, 4'd5, 32'(i + 100), 4'd0, 4'(i + 1),
              32'h5000 + 32'(4 * i));
         tick();
         check_issue("fill");
      end
      chk("fill_full", 64'(disp_full_out), 64'd1);
      chk("fill_count", 64'(count_out), 64'd8);
      disp(6'd7, 32'h99, 32'd0, 4'd0, 32'd0, 4'd0, 4'd12, 32'h9999);
      tick();
      check_issue("fill_drop");
      chk("fill_drop_count", 64'(count_out), 64'd8);
      idle();
      cdb0_tag_in = 4'd5;
      cdb0_val_in = 32'h55;
      for (int i = 0; i < 8; i++)
         sb.push_back({6'd5, 32'(i), 32'h55, 32'(i + 100), 4'(i + 1),
                       32'h5000 + 32'(4 * i)});
      tick();
      check_issue("fill_cap");
      idle();
      for (int k = 1; k <= 8; k++) begin
         tick();
         check_issue("fill_issue");
         chk("fill_issue_count", 64'(count_out), 64'(8 - k));
      end
      drain("fill_drain", 3);

      // Flush with a dispatch in the same cycle.
      for (int i = 0; i < 4; i++) begin
         disp(6'd6, 32'h0, 32'd0, 4'd7, 32'd0, 4'd0, 4'(i + 1), 32'h6000);
         tick();
         check_issue("flush_fill");
      end
      chk("flush_pre_count", 64'(count_out), 64'd4);
      disp(6'd6, 32'h0, 32'd1, 4'd0, 32'd1, 4'd0, 4'd9, 32'h6100);
      rob_flush_in = 1'b1;
      tick();
      idle();
      chk("flush_count", 64'(count_out), 64'd0);
      chk("flush_opcode", 64'(sched_alu_opcode_out), 64'(NOP));
      chk("flush_full", 64'(disp_full_out), 64'd0);
      cdb0_tag_in = 4'd7;
      cdb0_val_in = 32'h77;
      tick();
      check_issue("flush_post");
      idle();
      drain("flush_post", 3);
      chk("flush_post_count", 64'(count_out), 64'd0);

      // Flush beats an issue that would have fired.
      disp(6'd8, 32'h0, 32'd3, 4'd0, 32'd4, 4'd0, 4'd2, 32'h6200);
      tick();
      idle();
      rob_flush_in = 1'b1;
      tick();
      idle();
      chk("flush_iss_opcode", 64'(sched_alu_opcode_out), 64'(NOP));
      chk("flush_iss_count", 64'(count_out), 64'd0);
      drain("flush_iss", 2);

      // Stall holds outputs and ignores dispatch.
      disp(6'd10, 32'h1, 32'd11, 4'd0, 32'd12, 4'd0, 4'd3, 32'h7000);
      sb.push_back({6'd10, 32'h1, 32'd11, 32'd12, 4'd3, 32'h7000});
      tick();
      check_issue("stall");
      disp(6'd11, 32'h2, 32'd21, 4'd0, 32'd22, 4'd0, 4'd4, 32'h7004);
      sb.push_back({6'd11, 32'h2, 32'd21, 32'd22, 4'd4, 32'h7004});
      tick();
      check_issue("stall");
      rdy_in = 1'b1;
      disp(6'd12, 32'h3, 32'd31, 4'd0, 32'd32, 4'd0, 4'd5, 32'h7008);
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold_op", 64'(sched_alu_opcode_out), 64'd10);
         chk("stall_hold_count", 64'(count_out), 64'd1);
      end
      idle();
      rdy_in = 1'b1;
      drain("stall_drain", 3);
      chk("stall_count", 64'(count_out), 64'd0);

      // Asynchronous reset mid-operation.
      disp(6'd13, 32'h0, 32'd0, 4'd3, 32'd0, 4'd0, 4'd1, 32'h8000);
      tick();
      disp(6'd13, 32'h0, 32'd0, 4'd3, 32'd0, 4'd0, 4'd2, 32'h8004);
      tick();
      idle();
      chk("mid_pre_count", 64'(count_out), 64'd2);
      #2;
      rst_in = 1'b0;
      #1;
      chk("mid_rst_count", 64'(count_out), 64'd0);
      chk("mid_rst_opcode", 64'(sched_alu_opcode_out), 64'(NOP));
      @(negedge clk_in);
      rst_in = 1'b1;
      cdb0_tag_in = 4'd3;
      cdb0_val_in = 32'h33;
      tick();
      check_issue("mid_rst");
      idle();
      drain("mid_rst", 3);
      chk("mid_rst_end_count", 64'(count_out), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
